// File: rtl/gate_bist_seq_if.sv
// Purpose: groups the BIST sequencer's run control, GATE drive/sample lines and result signals.
// Latency: none; this file holds wiring only.
// Backpressure: none; start is a level request that the sequencer samples only while idle.
interface gate_bist_seq_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             in_1;
  logic             in_2;
  logic             in_3;
  logic             out_and;
  logic             out_or;
  logic             out_nand;
  logic             out_nor;
  logic             out_not;
  logic             out_buf;
  logic             out_exor;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [2:0]       fail_vec;
  logic [6:0]       fail_mask;

  // Sequencer side: drives the GATE inputs and reports results.
  modport master (
    input  start, out_and, out_or, out_nand, out_nor, out_not, out_buf, out_exor,
    output in_1, in_2, in_3, busy, done, pass, err_cnt, fail_vec, fail_mask
  );

  // Environment side: requests runs, closes the loop through GATE, reads results.
  modport slave (
    output start, out_and, out_or, out_nand, out_nor, out_not, out_buf, out_exor,
    input  in_1, in_2, in_3, busy, done, pass, err_cnt, fail_vec, fail_mask
  );
endinterface

// File: rtl/gate_bist_seq.sv
// Purpose: self-test sequencer that walks all 8 GATE input vectors and checks the 7 outputs against golden values.
// Latency: done pulses 1+8*STEP_CYCLES clocks after start is accepted; busy is high for exactly 8*STEP_CYCLES clocks.
// Backpressure: none; start is ignored while a run is in progress and is never queued.
module gate_bist_seq #(
  parameter int STEP_CYCLES = 10,
  parameter int CNT_W       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  gate_bist_seq_if.master bus
);

  localparam int                STEP_W    = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t            state_q;
  logic [STEP_W-1:0] step_q;
  logic [2:0]        vec_q;      // vector currently driven: {in_3,in_2,in_1}
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [2:0]        fail_vec_q;
  logic [6:0]        fail_mask_q;

  logic [6:0]        actual;
  logic [6:0]        golden;
  logic [6:0]        mask;
  logic              hit;

  // Golden response for the driven vector and per-bit mismatch; X/Z on the outputs registers as a mismatch.
  always_comb begin
    actual    = {bus.out_exor, bus.out_buf, bus.out_not, bus.out_nor,
                 bus.out_nand, bus.out_or, bus.out_and};
    golden    = '0;
    golden[0] = &vec_q;
    golden[1] = |vec_q;
    golden[2] = ~(&vec_q);
    golden[3] = ~(|vec_q);
    golden[4] = ~vec_q[0];
    golden[5] = vec_q[0];
    golden[6] = ^vec_q;
    mask      = actual ^ golden;
    hit       = (actual !== golden);
  end

  // Run sequencer: accepts start in idle, steps through vectors, compares in the last hold clock, reports in FIN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_vec_q  <= '0;
      fail_mask_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          vec_q  <= '0;
          if (bus.start) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            step_q      <= '0;
            err_cnt_q   <= '0;
            fail_vec_q  <= '0;
            fail_mask_q <= '0;
            pass_q      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (step_q == STEP_LAST) begin
            step_q <= '0;
            if (hit) begin
              if (err_cnt_q != CNT_MAX) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
              end
              // A zero count means no earlier vector in this run has failed.
              if (err_cnt_q == '0) begin
                fail_vec_q  <= vec_q;
                fail_mask_q <= mask;
              end
            end
            if (vec_q == 3'd7) begin
              state_q <= ST_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              vec_q   <= '0;
              pass_q  <= (err_cnt_q == '0) && !hit;
            end else begin
              vec_q <= vec_q + 3'd1;
            end
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          vec_q   <= '0;
        end
      endcase
    end
  end

  assign bus.in_1      = vec_q[0];
  assign bus.in_2      = vec_q[1];
  assign bus.in_3      = vec_q[2];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.fail_vec  = fail_vec_q;
  assign bus.fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_bist_seq.sv
// Purpose: drives two sequencers (4-bit and 3-bit error counters) against a GATE model with injectable faults.
// Latency: checks done at 1+8*S clocks, busy for 8*S clocks, and the vector sequence clock by clock.
// Backpressure: checks that start is ignored mid-run and that a held start restarts after one idle clock.
module tb_gate_bist_seq;

  localparam int S = 4;

  typedef struct {
    logic [7:0][6:0] flips;   // per-vector output flip mask applied by the GATE model
    int              cnt4;
    int              cnt3;
    logic [2:0]      vec;
    logic [6:0]      mask;
    logic            pass;
  } row_t;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [7:0][6:0] flips_cur;
  logic [6:0]      ga;
  logic [6:0]      gb;
  int              checks;
  int              errors;

  gate_bist_seq_if #(.CNT_W(4)) ifa ();
  gate_bist_seq_if #(.CNT_W(3)) ifb ();

  gate_bist_seq #(.STEP_CYCLES(S), .CNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  gate_bist_seq #(.STEP_CYCLES(S), .CNT_W(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] golden(input logic [2:0] v);
    logic a, b, c;
    a = v[0];
    b = v[1];
    c = v[2];
    return {a ^ b ^ c, a, ~a, ~(a | b | c), ~(a & b & c), a | b | c, a & b & c};
  endfunction

  // GATE model with faults: each vector's outputs are flipped by its entry in flips_cur.
  always_comb begin
    ga = golden({ifa.in_3, ifa.in_2, ifa.in_1}) ^ flips_cur[{ifa.in_3, ifa.in_2, ifa.in_1}];
    gb = golden({ifb.in_3, ifb.in_2, ifb.in_1}) ^ flips_cur[{ifb.in_3, ifb.in_2, ifb.in_1}];
  end

  assign {ifa.out_exor, ifa.out_buf, ifa.out_not, ifa.out_nor, ifa.out_nand, ifa.out_or, ifa.out_and} = ga;
  assign {ifb.out_exor, ifb.out_buf, ifb.out_not, ifb.out_nor, ifb.out_nand, ifb.out_or, ifb.out_and} = gb;
  assign ifa.start = start;
  assign ifb.start = start;

  // Reference: the expected report is read straight off the list of faulty vectors.
  function automatic row_t model(input logic [7:0][6:0] fl);
    row_t r;
    int   n;
    n       = 0;
    r.flips = fl;
    r.vec   = '0;
    r.mask  = '0;
    for (int k = 0; k < 8; k++) begin
      if (fl[k] != 7'd0) begin
        if (n == 0) begin
          r.vec  = 3'(k);
          r.mask = fl[k];
        end
        n++;
      end
    end
    r.cnt4 = (n > 15) ? 15 : n;
    r.cnt3 = (n > 7) ? 7 : n;
    r.pass = (n == 0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run from idle: checks the clock-by-clock drive pattern, then the report and its stability.
  task automatic run(input row_t r, input bit repulse, input bit hold);
    int seq_bad;
    logic [2:0] exp_in;
    logic exp_busy, exp_done;
    flips_cur = r.flips;
    start     = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    seq_bad = 0;
    chk("clear", {ifa.err_cnt, ifa.fail_vec, ifa.fail_mask, ifa.pass}, 32'd0);
    for (int c = 1; c <= 8 * S + 1; c++) begin
      if (c <= 8 * S) begin
        exp_busy = 1'b1;
        exp_done = 1'b0;
        exp_in   = 3'((c - 1) / S);
      end else begin
        exp_busy = 1'b0;
        exp_done = 1'b1;
        exp_in   = 3'd0;
      end
      if ({ifa.busy, ifa.done, ifa.in_3, ifa.in_2, ifa.in_1} !== {exp_busy, exp_done, exp_in}) seq_bad++;
      if ({ifb.busy, ifb.done, ifb.in_3, ifb.in_2, ifb.in_1} !== {exp_busy, exp_done, exp_in}) seq_bad++;
      if (repulse && c == 3 * S + 1) start = 1'b1;
      else if (!hold) start = 1'b0;
      if (c <= 8 * S) tick();
    end
    chk("seq", 32'(seq_bad), 32'd0);
    chk("err_cnt", 32'(ifa.err_cnt), 32'(r.cnt4));
    chk("err_cnt_w3", 32'(ifb.err_cnt), 32'(r.cnt3));
    chk("fail_vec", 32'(ifa.fail_vec), 32'(r.vec));
    chk("fail_mask", 32'(ifa.fail_mask), 32'(r.mask));
    chk("pass", 32'(ifa.pass), 32'(r.pass));
    tick();
    chk("after_done", {ifa.busy, ifa.done, ifa.err_cnt, ifa.fail_vec, ifa.fail_mask, ifa.pass},
        {1'b0, 1'b0, 4'(r.cnt4), r.vec, r.mask, r.pass});
  endtask

  row_t tab [6];

  initial begin
    int n;
    int seen;
    row_t r;
    logic [7:0][6:0] fl;
    checks = 0;
    errors = 0;

    tab[0] = '{flips: '0, cnt4: 0, cnt3: 0, vec: 3'd0, mask: 7'h00, pass: 1'b1};
    tab[1] = '{flips: {{7{7'h02}}, 7'h00}, cnt4: 7, cnt3: 7, vec: 3'd1, mask: 7'h02, pass: 1'b0};
    tab[2] = '{flips: {8{7'h40}}, cnt4: 8, cnt3: 7, vec: 3'd0, mask: 7'h40, pass: 1'b0};
    tab[3] = '{flips: '0, cnt4: 0, cnt3: 0, vec: 3'd0, mask: 7'h00, pass: 1'b1};
    tab[4] = '{flips: {7'h7f, {7{7'h00}}}, cnt4: 1, cnt3: 1, vec: 3'd7, mask: 7'h7f, pass: 1'b0};
    tab[5] = '{flips: {7'h00, 7'h01, 7'h11, {5{7'h00}}}, cnt4: 2, cnt3: 2, vec: 3'd5, mask: 7'h11, pass: 1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    flips_cur = '0;
    repeat (3) tick();
    chk("reset_a", {ifa.in_3, ifa.in_2, ifa.in_1, ifa.busy, ifa.done, ifa.pass, ifa.err_cnt, ifa.fail_vec, ifa.fail_mask}, 32'd0);
    chk("reset_b", {ifb.in_3, ifb.in_2, ifb.in_1, ifb.busy, ifb.done, ifb.pass, ifb.err_cnt, ifb.fail_vec, ifb.fail_mask}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Table rows; row 1 also re-pulses start during vector 3, row 3 follows a failing run.
    for (int i = 0; i < 6; i++) run(tab[i], i == 1, 1'b0);

    // Start held high: one idle clock after done, then a fresh run.
    run(tab[2], 1'b0, 1'b1);
    tick();
    chk("restart_busy", {ifa.busy, ifa.in_3, ifa.in_2, ifa.in_1, ifa.err_cnt}, {1'b1, 3'd0, 4'd0});
    start = 1'b0;
    n = 1;
    while (!ifa.done && n < 200) begin
      tick();
      n++;
    end
    chk("restart_lat", 32'(n), 32'(8 * S + 1));
    chk("restart_cnt", 32'(ifa.err_cnt), 32'd8);
    tick();

    // Reset during vector 5 aborts the run with no done.
    flips_cur = tab[1].flips;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5 * S + 1) tick();
    chk("mid_vec5", {ifa.busy, ifa.in_3, ifa.in_2, ifa.in_1}, {1'b1, 3'd5});
    rst_n = 1'b0;
    tick();
    chk("mid_rst_a", {ifa.in_3, ifa.in_2, ifa.in_1, ifa.busy, ifa.done, ifa.pass, ifa.err_cnt, ifa.fail_vec, ifa.fail_mask}, 32'd0);
    chk("mid_rst_b", {ifb.in_3, ifb.in_2, ifb.in_1, ifb.busy, ifb.done, ifb.pass, ifb.err_cnt, ifb.fail_vec, ifb.fail_mask}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 * S; c++) begin
      tick();
      if (ifa.done || ifa.busy || ifb.done) seen++;
    end
    chk("no_done", 32'(seen), 32'd0);

    // Random fault patterns checked against the reference model.
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 8; k++) begin
        fl[k] = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
      end
      if (i == 0) fl = '{default: 7'h7f};
      r = model(fl);
      run(r, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
